// File: rtl/axi4_lite_master_queued.sv
// AXI4-Lite master with independent FIFO-queued write and read command paths,
// per-transaction timeout and registered completion status.
module axi4_lite_master_queued #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [2:0]  WPROT   = 3'b000,
    parameter logic [2:0]  RPROT   = 3'b000
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [AW-1:0]   WCMD_ADDR,
    input  logic [DW-1:0]   WCMD_DATA,
    input  logic [DW/8-1:0] WCMD_STRB,
    input  logic            WCMD_VALID,
    output logic            WCMD_READY,
    output logic            WSTS_VALID,
    output logic [2:0]      WSTS_RESP,
    input  logic [AW-1:0]   RCMD_ADDR,
    input  logic            RCMD_VALID,
    output logic            RCMD_READY,
    output logic            RSTS_VALID,
    output logic [DW-1:0]   RSTS_DATA,
    output logic [2:0]      RSTS_RESP,
    output logic            W_BUSY,
    output logic            R_BUSY,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic            M_AXI_AWVALID,
    output logic [2:0]      M_AXI_AWPROT,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic            M_AXI_ARVALID,
    output logic [2:0]      M_AXI_ARPROT,
    input  logic            M_AXI_ARREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY
);

    localparam int unsigned QW  = $clog2(QDEPTH);
    localparam int unsigned CW  = QW + 1;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned WQW = AW + DW + SW;
    localparam logic [CW-1:0] QFULL    = CW'(QDEPTH);
    localparam logic [31:0]   TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    // ---------------- write command queue ----------------
    logic [WQW-1:0] wq_mem [QDEPTH];
    logic [QW-1:0]  wq_wr, wq_rd;
    logic [CW-1:0]  wq_cnt, wq_cnt_nx;
    logic           wq_ready, wq_push, w_issue;

    assign wq_push = WCMD_VALID & wq_ready;

    always_comb begin
        wq_cnt_nx = wq_cnt;
        if (wq_push && !w_issue)
            wq_cnt_nx = wq_cnt + 1'b1;
        else if (!wq_push && w_issue)
            wq_cnt_nx = wq_cnt - 1'b1;
    end

    // Ready is registered so it is low during reset and reflects the count that
    // will hold at the next edge; a pop on the same edge never frees a full queue.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wq_wr    <= '0;
            wq_rd    <= '0;
            wq_cnt   <= '0;
            wq_ready <= 1'b0;
        end else begin
            if (wq_push) wq_wr <= wq_wr + 1'b1;
            if (w_issue) wq_rd <= wq_rd + 1'b1;
            wq_cnt   <= wq_cnt_nx;
            wq_ready <= (wq_cnt_nx != QFULL);
        end
    end

    always_ff @(posedge CLK) begin
        if (wq_push) wq_mem[wq_wr] <= {WCMD_ADDR, WCMD_DATA, WCMD_STRB};
    end

    // ---------------- read command queue ----------------
    logic [AW-1:0] rq_mem [QDEPTH];
    logic [QW-1:0] rq_wr, rq_rd;
    logic [CW-1:0] rq_cnt, rq_cnt_nx;
    logic          rq_ready, rq_push, r_issue;

    assign rq_push = RCMD_VALID & rq_ready;

    always_comb begin
        rq_cnt_nx = rq_cnt;
        if (rq_push && !r_issue)
            rq_cnt_nx = rq_cnt + 1'b1;
        else if (!rq_push && r_issue)
            rq_cnt_nx = rq_cnt - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rq_wr    <= '0;
            rq_rd    <= '0;
            rq_cnt   <= '0;
            rq_ready <= 1'b0;
        end else begin
            if (rq_push) rq_wr <= rq_wr + 1'b1;
            if (r_issue) rq_rd <= rq_rd + 1'b1;
            rq_cnt   <= rq_cnt_nx;
            rq_ready <= (rq_cnt_nx != QFULL);
        end
    end

    always_ff @(posedge CLK) begin
        if (rq_push) rq_mem[rq_wr] <= RCMD_ADDR;
    end

    // ---------------- write FSM ----------------
    wstate_t       w_state, w_next;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          aw_done, w_done, aw_hs, w_hs, b_hs, w_tmo, w_cmpl;
    logic [31:0]   w_tcnt;

    assign w_issue = (w_state == W_IDLE) && (wq_cnt != '0);
    assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs    = M_AXI_BVALID & M_AXI_BREADY;
    assign w_tmo   = (TIMEOUT != 0) && (w_state != W_IDLE) && (w_tcnt == TMO_LAST);
    assign w_cmpl  = (w_state == W_RESP) && b_hs;

    always_ff @(posedge CLK) begin
        if (!RESETN) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:      if (w_issue) w_next = W_ADDR_DATA;
            W_ADDR_DATA: begin
                if (w_tmo)
                    w_next = W_IDLE;
                else if ((aw_done | aw_hs) & (w_done | w_hs))
                    w_next = W_RESP;
            end
            W_RESP:      if (w_cmpl || w_tmo) w_next = W_IDLE;
            default:     w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            w_tcnt     <= '0;
            WSTS_VALID <= 1'b0;
            WSTS_RESP  <= '0;
        end else begin
            WSTS_VALID <= 1'b0;
            if (w_issue) begin
                {aw_addr_q, w_data_q, w_strb_q} <= wq_mem[wq_rd];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                w_tcnt  <= '0;
            end else if (w_state != W_IDLE) begin
                w_tcnt <= w_tcnt + 32'd1;
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (w_cmpl) begin
                WSTS_VALID <= 1'b1;
                WSTS_RESP  <= {1'b0, M_AXI_BRESP};
            end else if (w_tmo) begin
                WSTS_VALID <= 1'b1;
                WSTS_RESP  <= 3'b110;
            end
        end
    end

    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWPROT  = WPROT;
    assign M_AXI_AWVALID = (w_state == W_ADDR_DATA) && !aw_done;
    assign M_AXI_WDATA   = w_data_q;
    assign M_AXI_WSTRB   = w_strb_q;
    assign M_AXI_WVALID  = (w_state == W_ADDR_DATA) && !w_done;
    assign M_AXI_BREADY  = (w_state != W_IDLE);
    assign WCMD_READY    = wq_ready;
    assign W_BUSY        = (wq_cnt != '0) || (w_state != W_IDLE);

    // ---------------- read FSM ----------------
    rstate_t       r_state, r_next;
    logic [AW-1:0] ar_addr_q;
    logic          ar_hs, r_hs, r_tmo, r_cmpl;
    logic [31:0]   r_tcnt;

    assign r_issue = (r_state == R_IDLE) && (rq_cnt != '0);
    assign ar_hs   = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs    = M_AXI_RVALID & M_AXI_RREADY;
    assign r_tmo   = (TIMEOUT != 0) && (r_state != R_IDLE) && (r_tcnt == TMO_LAST);
    // R may complete in the same cycle as the AR handshake
    assign r_cmpl  = r_hs && (((r_state == R_ADDR) && ar_hs) || (r_state == R_DATA));

    always_ff @(posedge CLK) begin
        if (!RESETN) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (r_issue) r_next = R_ADDR;
            R_ADDR: begin
                if (r_cmpl || r_tmo)
                    r_next = R_IDLE;
                else if (ar_hs)
                    r_next = R_DATA;
            end
            R_DATA: if (r_cmpl || r_tmo) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ar_addr_q  <= '0;
            r_tcnt     <= '0;
            RSTS_VALID <= 1'b0;
            RSTS_DATA  <= '0;
            RSTS_RESP  <= '0;
        end else begin
            RSTS_VALID <= 1'b0;
            if (r_issue) begin
                ar_addr_q <= rq_mem[rq_rd];
                r_tcnt    <= '0;
            end else if (r_state != R_IDLE) begin
                r_tcnt <= r_tcnt + 32'd1;
            end
            if (r_cmpl) begin
                RSTS_VALID <= 1'b1;
                RSTS_DATA  <= M_AXI_RDATA;
                RSTS_RESP  <= {1'b0, M_AXI_RRESP};
            end else if (r_tmo) begin
                RSTS_VALID <= 1'b1;
                RSTS_DATA  <= '0;
                RSTS_RESP  <= 3'b110;
            end
        end
    end

    assign M_AXI_ARADDR  = ar_addr_q;
    assign M_AXI_ARPROT  = RPROT;
    assign M_AXI_ARVALID = (r_state == R_ADDR);
    assign M_AXI_RREADY  = (r_state != R_IDLE);
    assign RCMD_READY    = rq_ready;
    assign R_BUSY        = (rq_cnt != '0) || (r_state != R_IDLE);

endmodule

// File: tb/tb_axi4_lite_master_queued.sv
// Directed bench for axi4_lite_master_queued: the bench plays the AXI slave
// by hand and checks every output against hand-computed values.
module tb_axi4_lite_master_queued;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [31:0] WCMD_ADDR, WCMD_DATA;
    logic [3:0]  WCMD_STRB;
    logic        WCMD_VALID, WCMD_READY;
    logic        WSTS_VALID;
    logic [2:0]  WSTS_RESP;
    logic [31:0] RCMD_ADDR;
    logic        RCMD_VALID, RCMD_READY;
    logic        RSTS_VALID;
    logic [31:0] RSTS_DATA;
    logic [2:0]  RSTS_RESP;
    logic        W_BUSY, R_BUSY;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 CLK = ~CLK;

    axi4_lite_master_queued #(
        .DW(32), .AW(32), .QDEPTH(4), .TIMEOUT(16), .WPROT(3'b000), .RPROT(3'b000)
    ) dut (
        .CLK(CLK), .RESETN(RESETN),
        .WCMD_ADDR(WCMD_ADDR), .WCMD_DATA(WCMD_DATA), .WCMD_STRB(WCMD_STRB),
        .WCMD_VALID(WCMD_VALID), .WCMD_READY(WCMD_READY),
        .WSTS_VALID(WSTS_VALID), .WSTS_RESP(WSTS_RESP),
        .RCMD_ADDR(RCMD_ADDR), .RCMD_VALID(RCMD_VALID), .RCMD_READY(RCMD_READY),
        .RSTS_VALID(RSTS_VALID), .RSTS_DATA(RSTS_DATA), .RSTS_RESP(RSTS_RESP),
        .W_BUSY(W_BUSY), .R_BUSY(R_BUSY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned n;
        n = 0;
        while (!WCMD_READY && n < 20) begin @(negedge CLK); n++; end
        chk("push_w_ready", 64'(WCMD_READY), 64'd1);
        WCMD_ADDR = a; WCMD_DATA = d; WCMD_STRB = s; WCMD_VALID = 1'b1;
        @(negedge CLK);
        WCMD_VALID = 1'b0;
    endtask

    task automatic push_r(input logic [31:0] a);
        int unsigned n;
        n = 0;
        while (!RCMD_READY && n < 20) begin @(negedge CLK); n++; end
        chk("push_r_ready", 64'(RCMD_READY), 64'd1);
        RCMD_ADDR = a; RCMD_VALID = 1'b1;
        @(negedge CLK);
        RCMD_VALID = 1'b0;
    endtask

    // Accept AW+W together, then return B one cycle later and check the status pulse.
    task automatic slave_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] br);
        int unsigned n;
        n = 0;
        while (!M_AXI_AWVALID && n < 20) begin @(negedge CLK); n++; end
        chk("sw_awvalid", 64'(M_AXI_AWVALID), 64'd1);
        chk("sw_awaddr", 64'(M_AXI_AWADDR), 64'(a));
        chk("sw_wdata", 64'(M_AXI_WDATA), 64'(d));
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        @(negedge CLK);
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = br;
        @(negedge CLK);
        chk("sw_wsts_valid", 64'(WSTS_VALID), 64'd1);
        chk("sw_wsts_resp", 64'(WSTS_RESP), {62'd0, br});
        M_AXI_BVALID = 1'b0;
    endtask

    initial begin
        int unsigned n;
        RESETN = 1'b0;
        WCMD_ADDR = '0; WCMD_DATA = '0; WCMD_STRB = '0; WCMD_VALID = 1'b0;
        RCMD_ADDR = '0; RCMD_VALID = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = '0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
        repeat (3) @(negedge CLK);

        // reset values
        chk("rst_wcmd_ready", 64'(WCMD_READY), 64'd0);
        chk("rst_rcmd_ready", 64'(RCMD_READY), 64'd0);
        chk("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
        chk("rst_bready", 64'(M_AXI_BREADY), 64'd0);
        chk("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("rst_w_busy", 64'(W_BUSY), 64'd0);
        chk("rst_rsts_data", 64'(RSTS_DATA), 64'd0);
        RESETN = 1'b1;
        @(negedge CLK);
        chk("post_rst_wcmd_ready", 64'(WCMD_READY), 64'd1);
        chk("post_rst_rcmd_ready", 64'(RCMD_READY), 64'd1);

        // single write, slave ready immediately
        push_w(32'h10, 32'hDEADBEEF, 4'hF);
        chk("w1_awvalid_wait", 64'(M_AXI_AWVALID), 64'd0);
        chk("w1_busy", 64'(W_BUSY), 64'd1);
        @(negedge CLK);
        chk("w1_awvalid", 64'(M_AXI_AWVALID), 64'd1);
        chk("w1_wvalid", 64'(M_AXI_WVALID), 64'd1);
        chk("w1_bready", 64'(M_AXI_BREADY), 64'd1);
        chk("w1_awaddr", 64'(M_AXI_AWADDR), 64'h10);
        chk("w1_wdata", 64'(M_AXI_WDATA), 64'hDEADBEEF);
        chk("w1_wstrb", 64'(M_AXI_WSTRB), 64'hF);
        chk("w1_awprot", 64'(M_AXI_AWPROT), 64'd0);
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        @(negedge CLK);
        chk("w1_awvalid_drop", 64'(M_AXI_AWVALID), 64'd0);
        chk("w1_wvalid_drop", 64'(M_AXI_WVALID), 64'd0);
        chk("w1_bready_resp", 64'(M_AXI_BREADY), 64'd1);
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        @(negedge CLK);
        chk("w1_wsts_valid", 64'(WSTS_VALID), 64'd1);
        chk("w1_wsts_resp", 64'(WSTS_RESP), 64'd0);
        chk("w1_bready_low", 64'(M_AXI_BREADY), 64'd0);
        M_AXI_BVALID = 1'b0;
        @(negedge CLK);
        chk("w1_wsts_pulse_end", 64'(WSTS_VALID), 64'd0);
        chk("w1_idle", 64'(W_BUSY), 64'd0);

        // W handshake 3 cycles before AW, then SLVERR
        push_w(32'h14, 32'hCAFEF00D, 4'h3);
        @(negedge CLK);
        chk("w2_awvalid", 64'(M_AXI_AWVALID), 64'd1);
        chk("w2_wstrb", 64'(M_AXI_WSTRB), 64'h3);
        M_AXI_WREADY = 1'b1;
        @(negedge CLK);
        chk("w2_wvalid_drop", 64'(M_AXI_WVALID), 64'd0);
        chk("w2_awvalid_hold1", 64'(M_AXI_AWVALID), 64'd1);
        M_AXI_WREADY = 1'b0;
        @(negedge CLK);
        chk("w2_awvalid_hold2", 64'(M_AXI_AWVALID), 64'd1);
        @(negedge CLK);
        chk("w2_awvalid_hold3", 64'(M_AXI_AWVALID), 64'd1);
        chk("w2_wvalid_low", 64'(M_AXI_WVALID), 64'd0);
        M_AXI_AWREADY = 1'b1;
        @(negedge CLK);
        chk("w2_awvalid_drop", 64'(M_AXI_AWVALID), 64'd0);
        chk("w2_no_early_sts", 64'(WSTS_VALID), 64'd0);
        M_AXI_AWREADY = 1'b0; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
        @(negedge CLK);
        chk("w2_wsts_valid", 64'(WSTS_VALID), 64'd1);
        chk("w2_wsts_resp", 64'(WSTS_RESP), 64'b010);
        M_AXI_BVALID = 1'b0;
        @(negedge CLK);

        // queue fill: cmd0 goes in flight, cmd1..4 fill the 4 entries, cmd5 is held
        for (int i = 0; i < 5; i++) begin
            chk("wq_fill_ready", 64'(WCMD_READY), 64'd1);
            WCMD_ADDR = 32'h100 + 32'(4 * i); WCMD_DATA = 32'hA0000000 + 32'(i);
            WCMD_STRB = 4'hF; WCMD_VALID = 1'b1;
            @(negedge CLK);
        end
        chk("wq_full_ready", 64'(WCMD_READY), 64'd0);
        WCMD_ADDR = 32'h114; WCMD_DATA = 32'hA0000005; WCMD_VALID = 1'b1;
        @(negedge CLK);
        chk("wq_held_ready", 64'(WCMD_READY), 64'd0);
        chk("wq_inflight_addr", 64'(M_AXI_AWADDR), 64'h100);
        WCMD_VALID = 1'b0;
        slave_write(32'h100, 32'hA0000000, 2'b00);
        push_w(32'h114, 32'hA0000005, 4'hF);
        for (int i = 1; i < 6; i++)
            slave_write(32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 2'(i));
        @(negedge CLK);
        chk("wq_drained", 64'(W_BUSY), 64'd0);

        // read with AR and R in the same cycle
        push_r(32'h20);
        chk("r1_arvalid_wait", 64'(M_AXI_ARVALID), 64'd0);
        chk("r1_busy", 64'(R_BUSY), 64'd1);
        @(negedge CLK);
        chk("r1_arvalid", 64'(M_AXI_ARVALID), 64'd1);
        chk("r1_rready", 64'(M_AXI_RREADY), 64'd1);
        chk("r1_araddr", 64'(M_AXI_ARADDR), 64'h20);
        chk("r1_arprot", 64'(M_AXI_ARPROT), 64'd0);
        M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h12345678; M_AXI_RRESP = 2'b00;
        @(negedge CLK);
        chk("r1_rsts_valid", 64'(RSTS_VALID), 64'd1);
        chk("r1_rsts_data", 64'(RSTS_DATA), 64'h12345678);
        chk("r1_rsts_resp", 64'(RSTS_RESP), 64'd0);
        chk("r1_arvalid_drop", 64'(M_AXI_ARVALID), 64'd0);
        chk("r1_rready_drop", 64'(M_AXI_RREADY), 64'd0);
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        @(negedge CLK);
        chk("r1_pulse_end", 64'(RSTS_VALID), 64'd0);
        chk("r1_idle", 64'(R_BUSY), 64'd0);

        // read with R two cycles after AR
        push_r(32'h24);
        @(negedge CLK);
        chk("r2_arvalid", 64'(M_AXI_ARVALID), 64'd1);
        M_AXI_ARREADY = 1'b1;
        @(negedge CLK);
        chk("r2_arvalid_drop", 64'(M_AXI_ARVALID), 64'd0);
        chk("r2_rready_hold", 64'(M_AXI_RREADY), 64'd1);
        M_AXI_ARREADY = 1'b0;
        @(negedge CLK);
        chk("r2_no_sts", 64'(RSTS_VALID), 64'd0);
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hA5A50001; M_AXI_RRESP = 2'b11;
        @(negedge CLK);
        chk("r2_rsts_valid", 64'(RSTS_VALID), 64'd1);
        chk("r2_rsts_data", 64'(RSTS_DATA), 64'hA5A50001);
        chk("r2_rsts_resp", 64'(RSTS_RESP), 64'b011);
        M_AXI_RVALID = 1'b0;
        @(negedge CLK);

        // write timeout: B never arrives; next queued command issues afterwards
        push_w(32'h30, 32'h00000030, 4'hF);
        push_w(32'h34, 32'h00000034, 4'hF);
        chk("to_awvalid", 64'(M_AXI_AWVALID), 64'd1);
        chk("to_awaddr", 64'(M_AXI_AWADDR), 64'h30);
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        n = 1;
        @(negedge CLK);
        n++;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("to_bready", 64'(M_AXI_BREADY), 64'd1);
        while (!WSTS_VALID && n < 40) begin @(negedge CLK); n++; end
        chk("to_cycle", 64'(n), 64'd17);
        chk("to_wsts_valid", 64'(WSTS_VALID), 64'd1);
        chk("to_wsts_resp", 64'(WSTS_RESP), 64'b110);
        chk("to_bready_low", 64'(M_AXI_BREADY), 64'd0);
        chk("to_awvalid_low", 64'(M_AXI_AWVALID), 64'd0);
        @(negedge CLK);
        chk("to_next_awvalid", 64'(M_AXI_AWVALID), 64'd1);
        chk("to_next_awaddr", 64'(M_AXI_AWADDR), 64'h34);
        slave_write(32'h34, 32'h00000034, 2'b00);
        @(negedge CLK);

        // reset while waiting for B, with another write queued
        push_w(32'h40, 32'h00000040, 4'hF);
        push_w(32'h44, 32'h00000044, 4'hF);
        chk("rr_awvalid", 64'(M_AXI_AWVALID), 64'd1);
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        @(negedge CLK);
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("rr_in_resp", 64'(M_AXI_BREADY), 64'd1);
        RESETN = 1'b0; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        @(negedge CLK);
        chk("rr_no_wsts", 64'(WSTS_VALID), 64'd0);
        chk("rr_bready", 64'(M_AXI_BREADY), 64'd0);
        chk("rr_awvalid_low", 64'(M_AXI_AWVALID), 64'd0);
        chk("rr_w_busy", 64'(W_BUSY), 64'd0);
        chk("rr_wcmd_ready", 64'(WCMD_READY), 64'd0);
        RESETN = 1'b1; M_AXI_BVALID = 1'b0;
        @(negedge CLK);
        chk("rr_post_wsts", 64'(WSTS_VALID), 64'd0);
        chk("rr_post_ready", 64'(WCMD_READY), 64'd1);
        chk("rr_post_busy", 64'(W_BUSY), 64'd0);
        @(negedge CLK);
        chk("rr_queue_discarded", 64'(M_AXI_AWVALID), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
